display_page_scheduler: RTL and testbench
=========================================

// Module: display_page_scheduler
// PURPOSE
//  Shares the 4-digit seven-segment display among four 32-bit sources (e.g. ALU result, PC, reg probe,
//  cycle count). Rotates the displayed page on a dwell timer or a next-page pulse.
//  Converts the selected value to 4 packed BCD digits with a sequential shift-add-3 engine.
//  Sits between the core's debug taps and the seven-segment digit driver, which consumes bcd_out.
// PARAMETERS
//  DWELL_CYCLES  100_000_000  clocks per page dwell / refresh tick (1 s at 100 MHz); must be >= 32
//  SAT_MAX       9999         largest displayable value; larger inputs saturate to this
// PORTS
//  clock_100Mhz  in   1    system clock, all state on rising edge
//  reset         in   1    asynchronous, active-low reset (0 = reset asserted)
//  src_bus       in   128  source i = src_bus[32*i+31:32*i], unsigned
//  src_enable    in   4    bit i = 1: page i is part of the rotation
//  next_page     in   1    single-cycle pulse (debounced upstream): advance page now
//  hold          in   1    1 = freeze rotation; dwell ticks only re-convert the current page
//  page          out  2    index of the page currently shown in bcd_out
//  bcd_out       out  16   {thousands, hundreds, tens, ones}, 4 bits each
//  overflow      out  1    1 = last converted value exceeded SAT_MAX and was clamped
//  busy          out  1    1 while the conversion FSM is not in IDLE
//  update        out  1    1-cycle pulse: bcd_out/page/overflow just changed
// BEHAVIOUR
//  Reset values: page=0, bcd_out=0, overflow=0, busy=0, update=0, dwell counter=0, pending flags=0.
//  Reset is applied asynchronously. It aborts any conversion in progress.
//  After reset is released, pend_refresh=1, so page 0 is converted automatically.
//  Dwell counter: counts 0..DWELL_CYCLES-1 and wraps. tick=1 in the cycle it holds DWELL_CYCLES-1.
//   The counter runs in every FSM state.
//  Event capture:
//   - next_page sets pend_adv.
//   - tick sets pend_adv if hold=0, else sets pend_refresh.
//   - Flags are sticky, 1 deep, and cleared when IDLE consumes them.
//   - Multiple events while busy collapse to at most one advance.
//   - next_page and tick in the same cycle advance exactly one page.
//  Page select on advance: next enabled index after page, searching page+1, page+2, ... mod 4.
//   - If only the current page is enabled, page stays and the page is re-converted.
//   - If src_enable=0, page is forced to 0 and page 0 is still converted.
//  FSM:
//   - IDLE: if pend_adv|pend_refresh (or event this cycle), choose page, clear flags, go LOAD.
//   - LOAD (1 cycle): sample src_bus word for the new page.
//     If value > SAT_MAX: bin = SAT_MAX, ovf_r=1; else bin = value[13:0], ovf_r=0.
//     Clear bcd accumulator. Set bit counter = 14. Go SHIFT.
//   - SHIFT (14 cycles): first add 3 to each BCD nibble >= 5, then shift {bcd,bin} left 1.
//     Decrement the bit counter. Go DONE when the count reaches 0.
//   - DONE (1 cycle): register bcd_out, page, overflow; update=1; go IDLE.
//  Latency: event sampled in IDLE at cycle t -> update=1 at cycle t+16, outputs valid same cycle.
//   busy=1 from t+1 through t+16.
//  Outputs: page/bcd_out/overflow change only in the update cycle and are stable otherwise.
//   The source is sampled once, in LOAD; changes during SHIFT do not affect the result.
//  Minimum event-to-event service time: 17 cycles.
//   A pending event is taken in the IDLE cycle right after DONE.
// TESTING
//  1. Release reset, src0=1234, src_enable=4'b1111
//     -> update at release+17, page=0, bcd_out=16'h1234, overflow=0.
//  2. src1=32'hFFFF_FFFF, next_page pulse -> page=1, bcd_out=16'h9999, overflow=1, 16 cycles later.
//  3. src_enable=4'b1001, page=0, DWELL_CYCLES=32
//     -> ticks rotate pages 0,3,0,3, one update per tick.
//  4. next_page and tick in the same cycle, then 3 next_page pulses while busy
//     -> exactly two page advances total.
//  5. hold=1, src2 changed 42->7 between ticks
//     -> page unchanged, bcd_out 16'h0042 then 16'h0007.
//  6. Assert reset at SHIFT cycle 5 -> outputs immediately 0.
//     After release, a fresh page-0 conversion completes correctly.

Source files
------------

// File: rtl/display_page_scheduler.sv
// Rotates four 32-bit debug sources onto a 4-digit BCD display, one page per dwell tick
// or next_page pulse, with a sequential shift-add-3 binary-to-BCD conversion per page.
module display_page_scheduler #(
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned SAT_MAX      = 9999
) (
    input  logic         clock_100Mhz,
    input  logic         reset,
    input  logic [127:0] src_bus,
    input  logic [3:0]   src_enable,
    input  logic         next_page,
    input  logic         hold,
    output logic [1:0]   page,
    output logic [15:0]  bcd_out,
    output logic         overflow,
    output logic         busy,
    output logic         update
);

    localparam int unsigned CW = $clog2(DWELL_CYCLES);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] dwell_cnt;
    logic          tick;
    logic          started, pend_adv, pend_refresh;
    logic          adv_now, refresh_now, take;
    logic [1:0]    sel_page;
    logic [31:0]   src_word;
    logic [13:0]   bin;
    logic [15:0]   bcd_acc, bcd_adj;
    logic [29:0]   shifted;
    logic [3:0]    bit_cnt;
    logic          ovf_r;

    function automatic logic [1:0] next_enabled(input logic [1:0] cur, input logic [3:0] en);
        logic [1:0] cand;
        logic       found;
        next_enabled = 2'd0;
        found        = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            cand = cur + 2'(i);
            if (!found && en[cand]) begin
                next_enabled = cand;
                found        = 1'b1;
            end
        end
    endfunction

    assign tick = (dwell_cnt == CW'(DWELL_CYCLES - 1));

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset)
            dwell_cnt <= '0;
        else if (tick)
            dwell_cnt <= '0;
        else
            dwell_cnt <= dwell_cnt + 1'b1;
    end

    always_comb begin
        adv_now     = pend_adv | next_page | (tick & ~hold);
        refresh_now = pend_refresh | (tick & hold);
        take        = (state == IDLE) & (adv_now | refresh_now);
    end

    // started=0 only in the first cycle after reset, which queues the automatic page-0 conversion
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            started      <= 1'b0;
            pend_adv     <= 1'b0;
            pend_refresh <= 1'b0;
        end else begin
            started <= 1'b1;
            if (take) begin
                pend_adv     <= 1'b0;
                pend_refresh <= 1'b0;
            end else begin
                if (next_page | (tick & ~hold))
                    pend_adv <= 1'b1;
                if ((tick & hold) | ~started)
                    pend_refresh <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        update    = 1'b0;
        case (state)
            IDLE: begin
                if (take)
                    state_nxt = LOAD;
            end
            LOAD: begin
                busy      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (bit_cnt == 4'd1)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                update    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        src_word = src_bus[{sel_page, 5'b0} +: 32];
        bcd_adj  = bcd_acc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin} << 1;
    end

    // Outputs load on the edge entering DONE so they are already valid while update is high
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            sel_page <= 2'd0;
            bin      <= '0;
            bcd_acc  <= '0;
            bit_cnt  <= '0;
            ovf_r    <= 1'b0;
            page     <= 2'd0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take)
                        sel_page <= adv_now ? next_enabled(page, src_enable) : page;
                end
                LOAD: begin
                    if (src_word > SAT_MAX) begin
                        bin   <= 14'(SAT_MAX);
                        ovf_r <= 1'b1;
                    end else begin
                        bin   <= src_word[13:0];
                        ovf_r <= 1'b0;
                    end
                    bcd_acc <= '0;
                    bit_cnt <= 4'd14;
                end
                SHIFT: begin
                    bcd_acc <= shifted[29:14];
                    bin     <= shifted[13:0];
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == 4'd1) begin
                        bcd_out  <= shifted[29:14];
                        page     <= sel_page;
                        overflow <= ovf_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_page_scheduler.sv
// Directed bench for display_page_scheduler with a 32-cycle dwell so ticks land at
// cycles 31, 63, 95, ... counted from each reset release.
module tb_display_page_scheduler;

    logic         clock_100Mhz = 1'b0;
    logic         reset;
    logic [127:0] src_bus;
    logic [3:0]   src_enable;
    logic         next_page;
    logic         hold;
    logic [1:0]   page;
    logic [15:0]  bcd_out;
    logic         overflow;
    logic         busy;
    logic         update;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clock_100Mhz = ~clock_100Mhz;

    display_page_scheduler #(
        .DWELL_CYCLES(32),
        .SAT_MAX     (9999)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .src_bus     (src_bus),
        .src_enable  (src_enable),
        .next_page   (next_page),
        .hold        (hold),
        .page        (page),
        .bcd_out     (bcd_out),
        .overflow    (overflow),
        .busy        (busy),
        .update      (update)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock_100Mhz);
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c)
            step();
    endtask

    task automatic set_src(input int idx, input logic [31:0] val);
        src_bus[32*idx +: 32] = val;
    endtask

    task automatic pulse_next();
        next_page = 1'b1;
        step();
        next_page = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        next_page = 1'b0;
        step();
        step();
        check("rst_page", 32'(page), 32'd0);
        check("rst_bcd", 32'(bcd_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_update", 32'(update), 32'd0);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic expect_update(input string tag, input int exp_cyc, input logic [1:0] exp_page,
                                 input logic [15:0] exp_bcd, input logic exp_ovf);
        do
            step();
        while (update !== 1'b1 && cyc < exp_cyc + 20);
        check({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_page"}, 32'(page), 32'(exp_page));
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp_bcd));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        reset      = 1'b0;
        src_bus    = '0;
        src_enable = 4'b1111;
        next_page  = 1'b0;
        hold       = 1'b0;

        // Power-up conversion, next_page with saturation, tick pended while busy
        set_src(0, 32'd1234);
        set_src(1, 32'hFFFF_FFFF);
        set_src(2, 32'd500);
        set_src(3, 32'd3);
        do_reset();
        run_to(1);
        check("a_idle_busy", 32'(busy), 32'd0);
        run_to(2);
        check("a_load_busy", 32'(busy), 32'd1);
        expect_update("a_init", 17, 2'd0, 16'h1234, 1'b0);
        run_to(18);
        check("a_post_update", 32'(update), 32'd0);
        check("a_post_busy", 32'(busy), 32'd0);
        pulse_next();
        run_to(33);
        check("a_stable_page", 32'(page), 32'd0);
        check("a_stable_bcd", 32'(bcd_out), 32'h1234);
        expect_update("a_sat", 34, 2'd1, 16'h9999, 1'b1);
        run_to(38);
        set_src(2, 32'd777);
        expect_update("a_tick", 51, 2'd2, 16'h0500, 1'b0);

        // Sparse enable: ticks alternate 0,3; exact SAT_MAX then SAT_MAX+1
        src_enable = 4'b1001;
        set_src(0, 32'd1234);
        set_src(3, 32'd9999);
        do_reset();
        expect_update("b_init", 17, 2'd0, 16'h1234, 1'b0);
        expect_update("b_t1", 47, 2'd3, 16'h9999, 1'b0);
        expect_update("b_t2", 79, 2'd0, 16'h1234, 1'b0);
        run_to(90);
        set_src(3, 32'd10000);
        expect_update("b_t3", 111, 2'd3, 16'h9999, 1'b1);
        expect_update("b_t4", 143, 2'd0, 16'h1234, 1'b0);

        // Collapsed events, then hold refreshes with a changed source
        src_enable = 4'b1111;
        set_src(0, 32'd1234);
        set_src(1, 32'd1);
        set_src(2, 32'd42);
        set_src(3, 32'd3);
        do_reset();
        expect_update("c_init", 17, 2'd0, 16'h1234, 1'b0);
        run_to(31);
        pulse_next();
        check("c_busy", 32'(busy), 32'd1);
        run_to(35);
        pulse_next();
        run_to(38);
        pulse_next();
        run_to(40);
        hold = 1'b1;
        run_to(41);
        pulse_next();
        expect_update("c_adv1", 47, 2'd1, 16'h0001, 1'b0);
        expect_update("c_adv2", 64, 2'd2, 16'h0042, 1'b0);
        expect_update("d_hold1", 81, 2'd2, 16'h0042, 1'b0);
        run_to(85);
        set_src(2, 32'd7);
        expect_update("d_hold2", 111, 2'd2, 16'h0007, 1'b0);

        // Reset in the fifth SHIFT cycle of the tick-127 refresh
        run_to(133);
        check("e_pre_busy", 32'(busy), 32'd1);
        check("e_pre_page", 32'(page), 32'd2);
        reset = 1'b0;
        #1;
        check("e_async_page", 32'(page), 32'd0);
        check("e_async_bcd", 32'(bcd_out), 32'd0);
        check("e_async_busy", 32'(busy), 32'd0);
        hold = 1'b0;
        set_src(0, 32'd5678);
        do_reset();
        expect_update("e_after", 17, 2'd0, 16'h5678, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
